// File: rtl/adc_byte_packer_pkg.sv
// Shared definitions for the ADC byte packer: FSM encoding, byte header markers
// and the width of one ADC sample word (overrange bit plus 10 data bits).
package adc_byte_packer_pkg;

    localparam int SAMPLE_W = 11;

    localparam logic HI_MARKER = 1'b1;
    localparam logic LO_MARKER = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LATCH = 3'd2,
        ST_HI    = 3'd3,
        ST_LO    = 3'd4
    } state_t;

endpackage

// File: rtl/adc_byte_packer_format.sv
// Splits one 11-bit ADC sample into the two bytes the host sees: a marked high
// byte carrying parity, overrange and D9..D7, and a low byte carrying D6..D0.
module adc_sample_format
    import adc_byte_packer_pkg::*;
(
    input  logic [SAMPLE_W-1:0] sample_i,
    output logic [7:0]          hi_byte_o,
    output logic [7:0]          lo_byte_o
);

    logic parity;

    // Parity covers the overrange bit as well, so the host can check all 11 bits.
    assign parity    = ^sample_i;
    assign hi_byte_o = {HI_MARKER, 2'b00, parity, sample_i[10:7]};
    assign lo_byte_o = {LO_MARKER, sample_i[6:0]};

endmodule

// File: rtl/adc_byte_packer.sv
// Pulls samples from the ADC sample FIFO and presents each one to the register
// interface as two bytes (high then low), with an optional per-start sample limit.
module adc_byte_packer
    import adc_byte_packer_pkg::*;
(
    input  logic                ftdi_clk,
    input  logic                reset,
    input  logic                start_i,
    input  logic [31:0]         maxsamples,
    input  logic                samp_empty,
    input  logic [SAMPLE_W-1:0] samp_data,
    output logic                samp_rd_en,
    output logic                byte_empty,
    output logic [7:0]          byte_data,
    input  logic                byte_rd_en,
    output logic                done_o,
    output logic [31:0]         sample_count_o
);

    state_t              state_q, state_d;
    logic                enable_q, enable_d;
    logic                samp_rd_en_q, samp_rd_en_d;
    logic                byte_empty_q, byte_empty_d;
    logic [7:0]          byte_data_q, byte_data_d;
    logic [31:0]         count_q, count_d;
    logic [SAMPLE_W-1:0] sample_q, sample_d;

    logic                limit_ok;
    logic [7:0]          hi_byte, lo_byte;

    adc_sample_format u_format (
        .sample_i  (sample_q),
        .hi_byte_o (hi_byte),
        .lo_byte_o (lo_byte)
    );

    assign limit_ok = (maxsamples == 32'd0) || (count_q != maxsamples);

    always_ff @(posedge ftdi_clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            enable_q     <= 1'b0;
            samp_rd_en_q <= 1'b0;
            byte_empty_q <= 1'b1;
            byte_data_q  <= 8'h00;
            count_q      <= 32'd0;
            sample_q     <= '0;
        end else begin
            state_q      <= state_d;
            enable_q     <= enable_d;
            samp_rd_en_q <= samp_rd_en_d;
            byte_empty_q <= byte_empty_d;
            byte_data_q  <= byte_data_d;
            count_q      <= count_d;
            sample_q     <= sample_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        enable_d     = enable_q;
        samp_rd_en_d = 1'b0;
        byte_data_d  = byte_data_q;
        count_d      = count_q;
        sample_d     = sample_q;

        case (state_q)
            ST_IDLE: begin
                if (enable_q && !samp_empty && limit_ok) begin
                    samp_rd_en_d = 1'b1;
                    state_d      = ST_FETCH;
                end
            end
            ST_FETCH: state_d = ST_LATCH;
            ST_LATCH: begin
                sample_d = samp_data;
                count_d  = count_q + 32'd1;
                state_d  = ST_HI;
            end
            ST_HI: begin
                if (byte_rd_en) begin
                    byte_data_d = hi_byte;
                    state_d     = ST_LO;
                end
            end
            ST_LO: begin
                if (byte_rd_en) begin
                    byte_data_d = lo_byte;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // start_i wins over everything above, including a byte read in the same cycle.
        if (start_i) begin
            state_d      = ST_IDLE;
            enable_d     = 1'b1;
            samp_rd_en_d = 1'b0;
            count_d      = 32'd0;
            byte_data_d  = byte_data_q;
        end

        byte_empty_d = !((state_d == ST_HI) || (state_d == ST_LO));
    end

    assign samp_rd_en     = samp_rd_en_q;
    assign byte_empty     = byte_empty_q;
    assign byte_data      = byte_data_q;
    assign sample_count_o = count_q;
    assign done_o         = (maxsamples != 32'd0) && (count_q == maxsamples) && byte_empty_q;

endmodule

// File: tb/tb_adc_byte_packer.sv
// Directed bench for adc_byte_packer: a vector table for byte formatting plus
// hand-written sequences for sample limit, start abort and reset in LO.
module tb_adc_byte_packer;

    logic        ftdi_clk = 1'b0;
    logic        reset;
    logic        start_i;
    logic [31:0] maxsamples;
    logic        samp_empty;
    logic [10:0] samp_data;
    logic        samp_rd_en;
    logic        byte_empty;
    logic [7:0]  byte_data;
    logic        byte_rd_en;
    logic        done_o;
    logic [31:0] sample_count_o;

    int checks   = 0;
    int failures = 0;

    adc_byte_packer dut (
        .ftdi_clk       (ftdi_clk),
        .reset          (reset),
        .start_i        (start_i),
        .maxsamples     (maxsamples),
        .samp_empty     (samp_empty),
        .samp_data      (samp_data),
        .samp_rd_en     (samp_rd_en),
        .byte_empty     (byte_empty),
        .byte_data      (byte_data),
        .byte_rd_en     (byte_rd_en),
        .done_o         (done_o),
        .sample_count_o (sample_count_o)
    );

    always #5 ftdi_clk = ~ftdi_clk;

    // Sample FIFO model: data appears the cycle after a read strobe.
    logic [10:0] fifo_mem [0:31];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int rd_cnt = 0;

    assign samp_empty = (wr_ptr == rd_ptr);

    always @(posedge ftdi_clk) begin
        if (samp_rd_en) begin
            rd_cnt <= rd_cnt + 1;
            if (rd_ptr != wr_ptr) begin
                samp_data <= fifo_mem[rd_ptr % 32];
                rd_ptr    <= rd_ptr + 1;
            end
        end
    end

    typedef struct {
        logic [10:0] samp;
        logic [7:0]  hi;
        logic [7:0]  lo;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge ftdi_clk);
    endtask

    task automatic push(input logic [10:0] s);
        fifo_mem[wr_ptr % 32] = s;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic read_byte(output logic [7:0] b);
        byte_rd_en = 1'b1;
        tick();
        byte_rd_en = 1'b0;
        b = byte_data;
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (byte_empty && n < 20) begin
            tick();
            n++;
        end
        chk(name, {31'd0, byte_empty}, 32'd0);
    endtask

    initial begin
        logic [7:0] b;
        int base;

        vecs[0] = '{11'h3FF, 8'h87, 8'h7F};
        vecs[1] = '{11'h401, 8'h88, 8'h01};
        vecs[2] = '{11'h200, 8'h94, 8'h00};
        vecs[3] = '{11'h000, 8'h80, 8'h00};
        vecs[4] = '{11'h7FF, 8'h9F, 8'h7F};
        vecs[5] = '{11'h555, 8'h8A, 8'h55};

        reset = 1'b1; start_i = 1'b0; maxsamples = 32'd0; byte_rd_en = 1'b0;
        samp_data = 11'h000;
        repeat (3) tick();
        chk("rst_byte_empty", {31'd0, byte_empty}, 32'd1);
        chk("rst_byte_data", {24'd0, byte_data}, 32'h00);
        chk("rst_samp_rd_en", {31'd0, samp_rd_en}, 32'd0);
        chk("rst_count", sample_count_o, 32'd0);
        chk("rst_done", {31'd0, done_o}, 32'd0);

        // Out of reset but not yet enabled: a queued sample must not be fetched.
        push(vecs[0].samp);
        reset = 1'b0;
        read_byte(b);
        chk("rd_while_empty_after_rst", {24'd0, b}, 32'h00);
        repeat (6) tick();
        chk("no_fetch_before_start", rd_cnt, 32'd0);

        maxsamples = 32'd0;
        base = rd_cnt;
        pulse_start();
        for (int i = 0; i < 6; i++) begin
            if (i > 0) begin
                base = rd_cnt;
                push(vecs[i].samp);
                tick(); tick();
                chk($sformatf("latency_still_empty_%0d", i), {31'd0, byte_empty}, 32'd1);
                tick();
                chk($sformatf("latency_ready_%0d", i), {31'd0, byte_empty}, 32'd0);
            end else begin
                wait_ready("first_ready");
            end
            read_byte(b);
            chk($sformatf("hi_byte_%0d", i), {24'd0, b}, {24'd0, vecs[i].hi});
            chk($sformatf("after_hi_not_empty_%0d", i), {31'd0, byte_empty}, 32'd0);
            read_byte(b);
            chk($sformatf("lo_byte_%0d", i), {24'd0, b}, {24'd0, vecs[i].lo});
            chk($sformatf("after_lo_empty_%0d", i), {31'd0, byte_empty}, 32'd1);
            chk($sformatf("one_rd_per_sample_%0d", i), rd_cnt - base, 32'd1);
        end
        chk("count_after_table", sample_count_o, 32'd6);

        read_byte(b);
        chk("rd_while_empty_holds", {24'd0, b}, 32'h55);

        // Sample limit of two with five queued.
        maxsamples = 32'd2;
        pulse_start();
        base = rd_cnt;
        push(11'h001); push(11'h47F); push(11'h200); push(11'h3FF); push(11'h555);
        wait_ready("lim_ready0");
        read_byte(b);
        chk("lim_hi0", {24'd0, b}, 32'h90);
        chk("lim_done_mid", {31'd0, done_o}, 32'd0);
        read_byte(b);
        chk("lim_lo0", {24'd0, b}, 32'h01);
        wait_ready("lim_ready1");
        read_byte(b);
        chk("lim_hi1", {24'd0, b}, 32'h88);
        read_byte(b);
        chk("lim_lo1", {24'd0, b}, 32'h7F);
        repeat (10) tick();
        chk("lim_rd_count", rd_cnt - base, 32'd2);
        chk("lim_done", {31'd0, done_o}, 32'd1);
        chk("lim_count", sample_count_o, 32'd2);
        chk("lim_byte_empty", {31'd0, byte_empty}, 32'd1);

        // start_i together with a byte read while in HI: abort, no byte load.
        maxsamples = 32'd0;
        pulse_start();
        wait_ready("abort_ready");
        start_i = 1'b1; byte_rd_en = 1'b1;
        tick();
        start_i = 1'b0; byte_rd_en = 1'b0;
        chk("abort_byte_data", {24'd0, byte_data}, 32'h7F);
        chk("abort_count", sample_count_o, 32'd0);
        chk("abort_byte_empty", {31'd0, byte_empty}, 32'd1);

        // Reset while in LO.
        wait_ready("lo_rst_ready");
        read_byte(b);
        chk("lo_rst_hi", {24'd0, b}, 32'h87);
        reset = 1'b1;
        #1;
        chk("lo_rst_byte_empty", {31'd0, byte_empty}, 32'd1);
        chk("lo_rst_byte_data", {24'd0, byte_data}, 32'h00);
        chk("lo_rst_count", sample_count_o, 32'd0);
        chk("lo_rst_samp_rd_en", {31'd0, samp_rd_en}, 32'd0);
        tick();
        reset = 1'b0;
        base = rd_cnt;
        repeat (8) tick();
        chk("lo_rst_no_fetch", rd_cnt - base, 32'd0);
        chk("lo_rst_still_empty", {31'd0, byte_empty}, 32'd1);
        chk("lo_rst_fifo_nonempty", {31'd0, samp_empty}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
